// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_BITS data LSB-first, optional parity, 1-2 stop bits.
// Shift register, baud counter, bit counter and frame FSM in one block.
module uart_tx_frame #(
   parameter int DATA_BITS  = 8,
   parameter int BAUD_DIV   = 109,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 trmt,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 TX,
   output logic                 busy,
   output logic                 tx_done
);

   // state  | meaning
   // IDLE   | line high, waiting for trmt
   // START  | driving start bit (0)
   // DATA   | driving shreg[0], shifting each bit period
   // PARITY | driving captured parity bit
   // STOP   | driving stop bit(s) (1)

   localparam int BAUD_W = $clog2(BAUD_DIV + 1);
   localparam int BIT_W  = $clog2(DATA_BITS + STOP_BITS + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(DATA_BITS + STOP_BITS - 1);
   localparam logic              PAR_INIT  = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t               state;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic [BAUD_W-1:0]    baud_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic                 baud_end;

   assign baud_end = (baud_cnt == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         shreg    <= '0;
         par_bit  <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         TX       <= 1'b1;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         if (state != IDLE)
            baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;

         case (state)
            IDLE: begin
               if (trmt) begin
                  shreg    <= tx_data;
                  // parity is fixed at capture so later shifting cannot disturb it
                  par_bit  <= (^tx_data) ^ PAR_INIT;
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  busy     <= 1'b1;
                  tx_done  <= 1'b0;
                  TX       <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (baud_end) begin
                  TX    <= shreg[0];
                  state <= DATA;
               end
            end
            DATA: begin
               if (baud_end) begin
                  shreg   <= shreg >> 1;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == DATA_LAST) begin
                     if (PARITY_EN != 0) begin
                        TX    <= par_bit;
                        state <= PARITY;
                     end else begin
                        TX    <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     TX <= shreg[1];
                  end
               end
            end
            PARITY: begin
               if (baud_end) begin
                  TX    <= 1'b1;
                  state <= STOP;
               end
            end
            STOP: begin
               if (baud_end) begin
                  // bit counter keeps running past the data bits to count stop bits
                  if (bit_cnt == STOP_LAST) begin
                     bit_cnt <= '0;
                     TX      <= 1'b1;
                     busy    <= 1'b0;
                     tx_done <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            default: begin
               TX    <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: five parameter sets sharing clk and rst.
module tb_uart_tx_frame;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] trmt_v;
   logic [8:0] tx_data;
   logic [4:0] tx_v, busy_v, done_v;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   uart_tx_frame u_8n1 (
      .clk(clk), .rst(rst), .trmt(trmt_v[0]), .tx_data(tx_data[7:0]),
      .TX(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));

   uart_tx_frame #(.PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
      .clk(clk), .rst(rst), .trmt(trmt_v[1]), .tx_data(tx_data[7:0]),
      .TX(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));

   uart_tx_frame #(.PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
      .clk(clk), .rst(rst), .trmt(trmt_v[2]), .tx_data(tx_data[7:0]),
      .TX(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]));

   uart_tx_frame #(.DATA_BITS(7), .STOP_BITS(2), .BAUD_DIV(4)) u_7n2 (
      .clk(clk), .rst(rst), .trmt(trmt_v[3]), .tx_data(tx_data[6:0]),
      .TX(tx_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]));

   uart_tx_frame #(.DATA_BITS(5), .BAUD_DIV(1)) u_5n1 (
      .clk(clk), .rst(rst), .trmt(trmt_v[4]), .tx_data(tx_data[4:0]),
      .TX(tx_v[4]), .busy(busy_v[4]), .tx_done(done_v[4]));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Starts a frame on instance idx (caller is at a negedge) and checks every bit's
   // first and last cycle plus the end-of-frame edge. bits[i] is the i-th bit on the wire.
   // With glitch set, trmt is re-pulsed mid-frame and at the busy-fall edge with 0x1FF.
   task automatic run_frame(input int idx, input logic [8:0] data, input logic [15:0] bits,
                            input int nbits, input int baud, input bit glitch, input string name);
      int last;
      last = nbits * baud;
      tx_data     = data;
      trmt_v[idx] = 1'b1;
      @(negedge clk);
      trmt_v[idx] = 1'b0;
      tx_data     = ~data;
      for (int m = 0; m <= last; m++) begin
         if (m == last) begin
            check_val($sformatf("%s end tx", name),   32'(tx_v[idx]),   32'd1);
            check_val($sformatf("%s end busy", name), 32'(busy_v[idx]), 32'd0);
            check_val($sformatf("%s end done", name), 32'(done_v[idx]), 32'd1);
         end else if ((m % baud == 0) || (m % baud == baud - 1)) begin
            check_val($sformatf("%s tx m=%0d", name, m),   32'(tx_v[idx]),   32'(bits[m / baud]));
            check_val($sformatf("%s busy m=%0d", name, m), 32'(busy_v[idx]), 32'd1);
            check_val($sformatf("%s done m=%0d", name, m), 32'(done_v[idx]), 32'd0);
         end
         trmt_v[idx] = glitch && ((m == 300) || (m == last - 1));
         if (glitch) tx_data = 9'h1FF;
         if (m < last) @(negedge clk);
      end
      trmt_v[idx] = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      trmt_v  = 5'b11111;
      tx_data = 9'h0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check_val($sformatf("reset tx%0d", i),   32'(tx_v[i]),   32'd1);
         check_val($sformatf("reset busy%0d", i), 32'(busy_v[i]), 32'd0);
         check_val($sformatf("reset done%0d", i), 32'(done_v[i]), 32'd0);
      end
      rst    = 1'b0;
      trmt_v = 5'b0;
      @(negedge clk);

      run_frame(0, 9'h0A5, 16'b1101001010,  10, 109, 1'b0, "8n1_a5");
      run_frame(1, 9'h007, 16'b11000001110, 11, 109, 1'b0, "8e1_07");
      run_frame(2, 9'h007, 16'b10000001110, 11, 109, 1'b0, "8o1_07");
      run_frame(3, 9'h055, 16'b1110101010,  10, 4,   1'b0, "7n2_55");
      run_frame(4, 9'h013, 16'b1100110,     7,  1,   1'b0, "5n1_13");

      // ignored re-pulses, then a restart one cycle after busy falls
      run_frame(0, 9'h0A5, 16'b1101001010,  10, 109, 1'b1, "glitch_a5");
      run_frame(0, 9'h03C, 16'b1001111000,  10, 109, 1'b0, "restart_3c");

      // reset mid-frame
      tx_data   = 9'h0A5;
      trmt_v[0] = 1'b1;
      @(negedge clk);
      trmt_v[0] = 1'b0;
      repeat (500) @(negedge clk);
      check_val("midframe busy", 32'(busy_v[0]), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("abort tx",   32'(tx_v[0]),   32'd1);
      check_val("abort busy", 32'(busy_v[0]), 32'd0);
      check_val("abort done", 32'(done_v[0]), 32'd0);
      run_frame(0, 9'h0A5, 16'b1101001010,  10, 109, 1'b0, "after_rst_a5");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
